// File: rtl/conv_frame_sequencer_if.sv
// Bus bundle for the convolution frame sequencer:
// pixel read port, engine stream, result write port, control/status.
interface conv_frame_sequencer_if #(
  parameter int DATA_WIDHT = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  hold;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDHT-1:0] rd_data;
  logic [DATA_WIDHT-1:0] conv_data;
  logic                  conv_valid;
  logic [DATA_WIDHT-1:0] conv_result;
  logic                  conv_rvalid;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDHT-1:0] wr_data;
  logic                  busy;
  logic                  done;
  logic                  err_extra;
  logic                  err_timeout;

  modport master (
    input  start, hold, rd_data,
    input  conv_result, conv_rvalid,
    output rd_en, rd_addr,
    output conv_data, conv_valid,
    output wr_en, wr_addr, wr_data,
    output busy, done,
    output err_extra, err_timeout
  );

  modport slave (
    output start, hold, rd_data,
    output conv_result, conv_rvalid,
    input  rd_en, rd_addr,
    input  conv_data, conv_valid,
    input  wr_en, wr_addr, wr_data,
    input  busy, done,
    input  err_extra, err_timeout
  );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Frame controller for the 3x3 conv engine: feeds pixels
// in raster order and stores the engine results.
module conv_frame_sequencer #(
  parameter int DATA_WIDHT    = 32,
  parameter int IMG_WIDTH     = 220,
  parameter int IMG_HEIGHT    = 220,
  parameter int ADDR_WIDTH    = 16,
  parameter int DRAIN_TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  conv_frame_sequencer_if.master bus
);

  localparam int PIX_TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int OUT_TOTAL = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [ADDR_WIDTH-1:0] PIX_END =
    ADDR_WIDTH'(PIX_TOTAL);
  localparam logic [ADDR_WIDTH-1:0] PIX_LAST =
    ADDR_WIDTH'(PIX_TOTAL - 1);
  localparam logic [ADDR_WIDTH-1:0] OUT_END =
    ADDR_WIDTH'(OUT_TOTAL);
  localparam logic [TW-1:0] TO_LAST =
    TW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [ADDR_WIDTH-1:0] out_cnt;
  logic [TW-1:0]         idle_cnt;
  logic                  vld_q;
  logic [DATA_WIDHT-1:0] data_q;
  logic                  rd_fire;
  logic                  res_ok;

  assign rd_fire = (state == FEED) && !bus.hold &&
                   (pix_cnt != PIX_END);
  assign res_ok  = bus.conv_rvalid &&
                   ((state == FEED) || (state == DRAIN)) &&
                   (out_cnt != OUT_END);

  assign bus.rd_en      = rd_fire;
  assign bus.rd_addr    = pix_cnt;
  assign bus.conv_valid = vld_q;
  // Memory data arrives one cycle after the read; forward it
  // straight to the engine and keep the last word otherwise.
  assign bus.conv_data  = vld_q ? bus.rd_data : data_q;
  assign bus.busy       = (state == FEED) || (state == DRAIN);
  assign bus.done       = (state == DONE);

  // Feed pipe: valid follows the read strobe by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q <= rd_fire;
      if (vld_q) data_q <= bus.rd_data;
    end
  end

  // Frame FSM with pixel/result counters and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pix_cnt         <= '0;
      out_cnt         <= '0;
      idle_cnt        <= '0;
      bus.wr_en       <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.err_extra   <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.wr_en <= res_ok;
      if (res_ok) begin
        bus.wr_addr <= out_cnt;
        bus.wr_data <= bus.conv_result;
        out_cnt     <= out_cnt + 1'b1;
      end else if (bus.conv_rvalid) begin
        bus.err_extra <= 1'b1;
      end
      if (rd_fire) pix_cnt <= pix_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (bus.start) begin
            state           <= FEED;
            pix_cnt         <= '0;
            out_cnt         <= '0;
            bus.err_extra   <= 1'b0;
            bus.err_timeout <= 1'b0;
          end
        end
        FEED: begin
          idle_cnt <= '0;
          if (rd_fire && (pix_cnt == PIX_LAST))
            state <= DRAIN;
        end
        DRAIN: begin
          if (out_cnt == OUT_END) begin
            state <= DONE;
          end else if (bus.conv_rvalid) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TO_LAST) begin
            bus.err_timeout <= 1'b1;
            state           <= DONE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        DONE: begin
          idle_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer on a 5x5 frame
// with a pixel memory model and a 3x3 sum engine model.
module tb_conv_frame_sequencer;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int NP = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_frame_sequencer_if #(
    .DATA_WIDHT(32),
    .ADDR_WIDTH(16)
  ) bus ();

  conv_frame_sequencer #(
    .DATA_WIDHT(32),
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H),
    .ADDR_WIDTH(16),
    .DRAIN_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;

  logic [31:0] mem [NP];

  int frame_id = 0;
  int eng_limit = 9;
  bit eng_extra = 1'b0;
  logic        eng_rv  = 1'b0;
  logic [31:0] eng_res = '0;
  logic        inj_rv  = 1'b0;
  logic [31:0] inj_res = '0;
  logic        nx_rv   = 1'b0;
  logic [31:0] nx_res  = '0;

  int rd_n, wr_n, done_n, drain_n;
  int cyc, first_cyc, last_cyc;
  logic [31:0] wr_first, wr_last;

  assign bus.conv_rvalid = eng_rv | inj_rv;
  assign bus.conv_result = inj_rv ? inj_res : eng_res;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] golden(input int o);
    int r, c;
    logic [31:0] s;
    r = o / (W - 2) + 2;
    c = o % (W - 2) + 2;
    s = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += mem[(r - i) * W + (c - j)];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_done(input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
  endtask

  // Pixel memory: sample the read at negedge, answer after
  // the next rising edge.
  initial begin
    logic        ren;
    logic [15:0] a;
    ren = 1'b0;
    a   = '0;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      ren = bus.rd_en;
      a   = bus.rd_addr;
      @(posedge clk);
      #1;
      if (ren) bus.rd_data = mem[32'(a)];
    end
  end

  // Engine model: 3x3 window sum over the received stream.
  initial begin
    int eid, rx_n, em_n, r, c;
    bit ext;
    logic [31:0] rxbuf [NP];
    logic [31:0] s;
    eid = 0; rx_n = 0; em_n = 0; ext = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_id != eid) begin
        eid = frame_id;
        rx_n = 0;
        em_n = 0;
        ext = 1'b0;
      end
      nx_rv = 1'b0;
      if (ext) begin
        nx_rv  = 1'b1;
        nx_res = 32'hbad0;
        ext    = 1'b0;
      end
      if (bus.conv_valid && rx_n < NP) begin
        rxbuf[rx_n] = bus.conv_data;
        r = rx_n / W;
        c = rx_n % W;
        if (r >= 2 && c >= 2 && em_n < eng_limit) begin
          s = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              s += rxbuf[(r - i) * W + (c - j)];
          nx_rv  = 1'b1;
          nx_res = s;
          em_n++;
          if (em_n == 9 && eng_extra) ext = 1'b1;
        end
        rx_n++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      eng_rv  = nx_rv;
      eng_res = nx_res;
    end
  end

  // Output monitor: read order, feed delay, result writes.
  initial begin
    int mid;
    logic        prev_ren;
    logic [15:0] prev_addr;
    mid = 0; prev_ren = 1'b0; prev_addr = '0;
    rd_n = 0; wr_n = 0; done_n = 0; drain_n = 0;
    cyc = 0; first_cyc = 0; last_cyc = 0;
    wr_first = '0; wr_last = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (frame_id != mid) begin
        mid = frame_id;
        rd_n = 0; wr_n = 0; done_n = 0; drain_n = 0;
      end
      chk("conv_valid", 32'(bus.conv_valid), 32'(prev_ren));
      if (bus.conv_valid)
        chk("conv_data", bus.conv_data, mem[32'(prev_addr)]);
      if (bus.rd_en) begin
        chk("rd_addr", 32'(bus.rd_addr), 32'(rd_n));
        if (rd_n == 0) first_cyc = cyc;
        last_cyc = cyc;
        rd_n++;
        drain_n = 0;
      end else if (bus.busy) begin
        drain_n++;
      end
      if (bus.wr_en) begin
        chk("wr_addr", 32'(bus.wr_addr), 32'(wr_n));
        chk("wr_data", bus.wr_data, golden(wr_n));
        if (wr_n == 0) wr_first = bus.wr_data;
        wr_last = bus.wr_data;
        wr_n++;
      end
      if (bus.done) done_n++;
      prev_ren  = bus.rd_en & ~rst;
      prev_addr = bus.rd_addr;
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_rd_en"}, 32'(bus.rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
    chk({tag, "_cvalid"}, 32'(bus.conv_valid), 0);
    chk({tag, "_cdata"}, bus.conv_data, 0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_eextra"}, 32'(bus.err_extra), 0);
    chk({tag, "_etmo"}, 32'(bus.err_timeout), 0);
  endtask

  task automatic start_frame();
    frame_id++;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int n;
    for (int k = 0; k < NP; k++) mem[k] = 32'(k * 7 + 3);
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    repeat (3) tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // 1: plain frame
    start_frame();
    run_done(100);
    tick();
    chk("t1_reads", 32'(rd_n), 25);
    chk("t1_span", 32'(last_cyc - first_cyc), 24);
    chk("t1_writes", 32'(wr_n), 9);
    chk("t1_first", wr_first, 32'd405);
    chk("t1_last", wr_last, 32'd1161);
    chk("t1_done_n", 32'(done_n), 1);
    chk("t1_drain", 32'(drain_n), 3);
    chk("t1_eextra", 32'(bus.err_extra), 0);
    chk("t1_etmo", 32'(bus.err_timeout), 0);
    chk("t1_busy", 32'(bus.busy), 0);

    // 2: hold three cycles at pixel 7
    start_frame();
    n = 0;
    while (bus.rd_addr != 16'd7 && n < 50) begin
      tick();
      n++;
    end
    chk("t2_reach7", 32'(bus.rd_addr), 7);
    bus.hold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_rd_en", 32'(bus.rd_en), 0);
      chk("t2_hold_addr", 32'(bus.rd_addr), 7);
      tick();
    end
    bus.hold = 1'b0;
    @(negedge clk);
    chk("t2_resume_en", 32'(bus.rd_en), 1);
    chk("t2_resume_addr", 32'(bus.rd_addr), 7);
    run_done(100);
    tick();
    chk("t2_reads", 32'(rd_n), 25);
    chk("t2_span", 32'(last_cyc - first_cyc), 27);
    chk("t2_writes", 32'(wr_n), 9);
    chk("t2_done_n", 32'(done_n), 1);

    // 3: engine stalls after 6 results
    eng_limit = 6;
    start_frame();
    run_done(300);
    tick();
    chk("t3_writes", 32'(wr_n), 6);
    chk("t3_drain", 32'(drain_n), 64);
    chk("t3_etmo", 32'(bus.err_timeout), 1);
    chk("t3_eextra", 32'(bus.err_extra), 0);
    chk("t3_done_n", 32'(done_n), 1);
    chk("t3_busy", 32'(bus.busy), 0);
    eng_limit = 9;

    // 4: stray results in IDLE and after the last one
    inj_res = 32'h1234;
    inj_rv  = 1'b1;
    tick();
    inj_rv  = 1'b0;
    chk("t4_idle_wr_en", 32'(bus.wr_en), 0);
    chk("t4_idle_eextra", 32'(bus.err_extra), 1);
    chk("t4_etmo_sticky", 32'(bus.err_timeout), 1);
    eng_extra = 1'b1;
    start_frame();
    chk("t4_clr_eextra", 32'(bus.err_extra), 0);
    chk("t4_clr_etmo", 32'(bus.err_timeout), 0);
    chk("t4_busy", 32'(bus.busy), 1);
    run_done(100);
    tick();
    chk("t4_writes", 32'(wr_n), 9);
    chk("t4_eextra", 32'(bus.err_extra), 1);
    chk("t4_etmo", 32'(bus.err_timeout), 0);
    eng_extra = 1'b0;

    // 5: reset mid-frame, then rerun
    start_frame();
    n = 0;
    while (bus.rd_addr != 16'd12 && n < 50) begin
      tick();
      n++;
    end
    chk("t5_reach12", 32'(bus.rd_addr), 12);
    rst = 1'b1;
    tick();
    chk_idle_outputs("t5_rst");
    rst = 1'b0;
    tick();
    start_frame();
    run_done(100);
    tick();
    chk("t5_reads", 32'(rd_n), 25);
    chk("t5_writes", 32'(wr_n), 9);
    chk("t5_done_n", 32'(done_n), 1);
    chk("t5_eextra", 32'(bus.err_extra), 0);

    // 6: start held high across a whole frame
    frame_id++;
    bus.start = 1'b1;
    tick();
    run_done(100);
    tick();
    chk("t6_idle_busy", 32'(bus.busy), 0);
    chk("t6_reads", 32'(rd_n), 25);
    chk("t6_done_n", 32'(done_n), 1);
    frame_id++;
    tick();
    chk("t6_restart_busy", 32'(bus.busy), 1);
    bus.start = 1'b0;
    run_done(100);
    tick();
    chk("t6b_reads", 32'(rd_n), 25);
    chk("t6b_writes", 32'(wr_n), 9);
    chk("t6b_done_n", 32'(done_n), 1);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
